// File: rtl/edge_event_reader_pkg.sv
// Shared definitions for the falling-edge event reader: FSM encoding,
// default monitored width and the index-width helper.
package edge_event_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Index width for a vector of w bits; never narrower than one bit.
    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/edge_event_reader_if.sv
// Valid/ready event channel carrying the bit index of a reported edge.
interface edge_event_reader_if
    import edge_event_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int IDXW = idx_w(WIDTH);

    logic            evt_valid;
    logic            evt_ready;
    logic [IDXW-1:0] evt_idx;

    modport master (output evt_valid, output evt_idx, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_idx, output evt_ready);
endinterface

// File: rtl/edge_event_reader_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping from WIDTH-1 back to 0.
module rr_pick
    import edge_event_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDXW  = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic             any,
    output logic [IDXW-1:0]  idx
);

    int p;

    // Scan from the farthest offset back toward ptr so the nearest hit wins.
    always_comb begin
        any = |req;
        idx = '0;
        p   = 0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            p = int'(ptr) + k;
            if (p >= WIDTH) p = p - WIDTH;
            if (req[p]) idx = IDXW'(p);
        end
    end

endmodule

// File: rtl/edge_event_reader.sv
// Latches 1->0 transitions on a monitored vector as sticky pending flags and
// reports them one index at a time over a valid/ready channel.
module edge_event_reader
    import edge_event_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDXW  = idx_w(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in,
    edge_event_reader_if.master   evt,
    output logic [WIDTH-1:0]      pending,
    output logic [WIDTH-1:0]      overflow
);

    state_t           state;
    logic [WIDTH-1:0] in_r;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic [IDXW-1:0]  ptr;
    logic             pick_any;
    logic [IDXW-1:0]  pick_idx;

    assign fall = in_r & ~in;

    always_comb begin
        clr = '0;
        if (evt.evt_valid && evt.evt_ready) clr[evt.evt_idx] = 1'b1;
    end

    rr_pick #(.WIDTH(WIDTH), .IDXW(IDXW)) u_pick (
        .req (pending),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // in_r keeps tracking during reset so no stale edge appears on release.
    always_ff @(posedge clk) begin
        in_r <= in;
        if (rst) begin
            pending       <= '0;
            overflow      <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_idx   <= '0;
            ptr           <= '0;
            state         <= ST_IDLE;
        end else begin
            // A new edge wins over a same-cycle clear and is not a loss.
            pending  <= (pending & ~clr) | fall;
            overflow <= overflow | (fall & pending & ~clr);
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        evt.evt_idx   <= pick_idx;
                        evt.evt_valid <= 1'b1;
                        state         <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt.evt_ready) begin
                        evt.evt_valid <= 1'b0;
                        ptr           <= (evt.evt_idx == IDXW'(WIDTH - 1)) ?
                                         '0 : evt.evt_idx + IDXW'(1);
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
